// File: rtl/i2c_master.sv
// Single-byte I2C master (write or read); done arrives 20 slots (11 on address NACK) of 4*CLK_DIV clks after start.
// No backpressure: start is taken only in IDLE, ignored while busy, never queued.
module i2c_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  wire        SDA
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WR, WACK, RD, RACK, STOP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;
    logic        div_last, sample, slot_end, sda_in;
    logic [7:0]  abyte;

    assign sda_in   = SDA;
    assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
    assign SCL      = scl_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;

    assign div_last = (div_q == 8'(CLK_DIV - 1));
    assign sample   = div_last && (phase_q == 2'd2);
    assign slot_end = div_last && (phase_q == 2'd3);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;

        // Phase and bit counters wrap on their own, so slots abut with no idle clk.
        if (state_q != IDLE) begin
            if (div_last) begin
                div_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                div_d   = div_q + 8'd1;
            end
        end

        unique case (state_q)
            IDLE: if (start) begin
                state_d   = START;
                addr_d    = addr;
                rw_d      = rw;
                wdata_d   = wdata;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                div_d     = '0;
                phase_d   = '0;
                bit_d     = '0;
            end
            START: if (slot_end) state_d = ADDR;
            ADDR: if (slot_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = AACK;
            end
            AACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (slot_end) state_d = ack_err_q ? STOP : (rw_q ? RD : WR);
            end
            WR: if (slot_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = WACK;
            end
            WACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (slot_end) state_d = STOP;
            end
            RD: begin
                if (sample) rdata_d = {rdata_q[6:0], sda_in};
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RACK;
                end
            end
            RACK: if (slot_end) state_d = STOP;
            STOP: if (slot_end) begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Line levels follow the next state so they register in step with it.
        abyte    = {addr_d, rw_d};
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        unique case (state_d)
            START: sda_oe_d = phase_d[1];
            ADDR: begin
                scl_d    = phase_d[1];
                sda_oe_d = ~abyte[~bit_d];
            end
            WR: begin
                scl_d    = phase_d[1];
                sda_oe_d = ~wdata_d[~bit_d];
            end
            AACK, WACK, RD, RACK: scl_d = phase_d[1];
            STOP: begin
                scl_d    = phase_d[1];
                sda_oe_d = (phase_d != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: bus monitor plus a single-byte slave model at 7'h55.
module tb_i2c_master;
    localparam int          CLK_DIV  = 4;
    localparam logic [6:0]  SLV_ADDR = 7'h55;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl;
    wire        sda;
    logic       sl_drv = 1'b0;
    logic [7:0] slv_rd = 8'hD5;

    pullup (sda);
    assign sda = sl_drv ? 1'b0 : 1'bz;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .SCL(scl), .SDA(sda)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor and slave; all sampling on the falling clk edge.
    int         cyc = 0, edge_n = 0, n_start = 0, n_stop = 0, n_viol = 0, last_rise = 0, per = 0;
    logic [7:0] cap_addr = '0, cap_data = '0;
    logic       rack_sda = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            edge_n = 0;
            sl_drv = 1'b0;
        end else begin
            if (scl && prev_scl && prev_sda && !sda) begin
                n_start++;
                edge_n   = 0;
                cap_addr = '0;
                cap_data = '0;
            end
            if (scl && prev_scl && !prev_sda && sda) n_stop++;
            if (scl && !prev_scl && (sda != prev_sda)) n_viol++;
            if (scl && !prev_scl) begin
                edge_n++;
                if (edge_n == 5) per = cyc - last_rise;
                last_rise = cyc;
                if (edge_n <= 8) cap_addr = {cap_addr[6:0], sda};
                else if (edge_n >= 10 && edge_n <= 17) cap_data = {cap_data[6:0], sda};
                else if (edge_n == 18) rack_sda = sda;
            end
            // On SCL fall, set up what the slave drives in slot edge_n+1.
            if (!scl && prev_scl) begin
                sl_drv = 1'b0;
                if (cap_addr[7:1] == SLV_ADDR) begin
                    if (edge_n == 8) sl_drv = 1'b1;
                    else if (cap_addr[0] && edge_n >= 9 && edge_n <= 16) sl_drv = ~slv_rd[16 - edge_n];
                    else if (!cap_addr[0] && edge_n == 17) sl_drv = 1'b1;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    int   lat, ndone, st0, sp0, vi0;
    logic ae;

    task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d, input int inj);
        st0 = n_start; sp0 = n_stop; vi0 = n_viol;
        @(negedge clk);
        rw = r; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rw = ~r; addr = ~a; wdata = ~d;
        check("busy_on", busy, 1);
        lat = 0; ae = 1'b0; ndone = 0;
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == inj) begin
                start = 1'b1; rw = 1'b1; addr = 7'h12; wdata = 8'h5C;
            end
            if (lat == inj + 1) start = 1'b0;
        end
        if (done) ndone = 1;
        ae = ack_err;
        check("busy_off_at_done", busy, 0);
        repeat (60) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("start_cnt", n_start - st0, 1);
        check("stop_cnt", n_stop - sp0, 1);
        check("sda_while_scl_high", n_viol - vi0, 0);
        check("done_pulses", ndone, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_rdata", rdata, 8'h00);
        rst_n = 1'b1;

        // Write A3 to 0x55
        run_txn(1'b0, 7'h55, 8'hA3, -10);
        check("wr_lat", lat, 320);
        check("wr_ack_err", ae, 0);
        check("wr_addr_byte", cap_addr, 8'hAA);
        check("wr_data_byte", cap_data, 8'hA3);
        check("scl_period", per, 16);
        check("wr_rdata_hold", rdata, 8'h00);

        // Read from 0x55, slave returns D5
        run_txn(1'b1, 7'h55, 8'h00, -10);
        check("rd_lat", lat, 320);
        check("rd_ack_err", ae, 0);
        check("rd_addr_byte", cap_addr, 8'hAB);
        check("rd_data_bus", cap_data, 8'hD5);
        check("rd_rdata", rdata, 8'hD5);
        check("rack_released", rack_sda, 1);

        // Address NACK
        run_txn(1'b0, 7'h12, 8'hFF, -10);
        check("nack_lat", lat, 176);
        check("nack_ack_err", ae, 1);
        check("nack_addr_byte", cap_addr, 8'h24);
        check("nack_scl_rises", edge_n, 10);
        check("nack_rdata_hold", rdata, 8'hD5);

        // Second start at clk 50 of a write is ignored
        run_txn(1'b0, 7'h55, 8'hA3, 50);
        check("busy_start_lat", lat, 320);
        check("busy_start_ack", ae, 0);
        check("busy_start_addr", cap_addr, 8'hAA);
        check("busy_start_data", cap_data, 8'hA3);

        // Reset during WR bit 4 (bit is 0, so SDA is being driven low)
        @(negedge clk);
        rw = 1'b0; addr = 7'h55; wdata = 8'hA3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (229) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_scl", scl, 0);
        check("pre_rst_sda", sda, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rdata", rdata, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 7'h55, 8'h3C, -10);
        check("post_rst_lat", lat, 320);
        check("post_rst_ack", ae, 0);
        check("post_rst_addr", cap_addr, 8'hAA);
        check("post_rst_data", cap_data, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
